icache_refill_ctrl: RTL and testbench

- Miss-handling and refill controller for the instruction cache; the writer side of the icache tag array.
- Takes a fetch request and samples the tag array's hit/valid one cycle later. On a miss it issues a burst read to memory and streams 8 words into the data RAM. It then writes the tag with valid set and replays the lookup.
- Sits between the fetch stage, the tag/data arrays and the memory read channel.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_refill_ctrl_if.sv | 51 +++++
 rtl/icache_refill_beat_cnt.sv | 38 +++
 rtl/icache_refill_ctrl.sv | 123 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared line geometry, address field positions and FSM state encoding for the
// icache refill controller (optional counters: ICACHE_PERF_CNT_EN).
package icache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int INDEX_W    = 7;
    localparam int TAG_W      = 20;
    localparam int OFFSET_W   = 5;
    localparam int WORD_OFF_W = 3;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;
    localparam int DATA_AW    = INDEX_W + WORD_OFF_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        AR     = 3'd2,
        RD     = 3'd3,
        TAGW   = 3'd4,
        REPLAY = 3'd5
    } state_t;

    // Tag array entry: valid bit on top of the tag.
    function automatic logic [TAG_W:0] tag_entry(input logic [TAG_W-1:0] tag);
        return {1'b1, tag};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, tag/data array and memory read-channel signals of the refill controller.
// hit_cnt/miss_cnt exist only when ICACHE_PERF_CNT_EN is defined.
interface icache_refill_ctrl_if;
    import icache_pkg::*;

    logic                 req;
    logic [31:0]          addr;
    logic                 ack;
    logic                 stall;
    logic                 tag_work;
    logic                 tag_hit;
    logic                 tag_valid;
    logic [31:0]          tag_addr;
    logic                 tag_wen;
    logic [TAG_W:0]       tag_wdata;
    logic                 data_wen;
    logic [DATA_AW-1:0]   data_waddr;
    logic [31:0]          data_wdata;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [31:0]          ar_addr;
    logic [7:0]           ar_len;
    logic                 r_valid;
    logic [31:0]          r_data;
    logic                 r_last;
    logic                 r_ready;
    logic                 err;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]          hit_cnt;
    logic [31:0]          miss_cnt;
`endif

    modport master (
`ifdef ICACHE_PERF_CNT_EN
        output hit_cnt, miss_cnt,
`endif
        input  req, addr, tag_work, tag_hit, tag_valid, ar_ready, r_valid, r_data, r_last,
        output ack, stall, tag_addr, tag_wen, tag_wdata, data_wen, data_waddr, data_wdata,
        output ar_valid, ar_addr, ar_len, r_ready, err
    );

    modport slave (
`ifdef ICACHE_PERF_CNT_EN
        input  hit_cnt, miss_cnt,
`endif
        output req, addr, tag_work, tag_hit, tag_valid, ar_ready, r_valid, r_data, r_last,
        input  ack, stall, tag_addr, tag_wen, tag_wdata, data_wen, data_waddr, data_wdata,
        input  ar_valid, ar_addr, ar_len, r_ready, err
    );

endinterface

// File: rtl/icache_refill_beat_cnt.sv
// Refill beat counter: tracks the word offset of each accepted beat, flags the end
// of the burst and latches a sticky error when r_last disagrees with the line length.
module icache_refill_beat_cnt
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  beat,
    input  logic                  last,
    output logic [WORD_OFF_W-1:0] cnt,
    output logic                  done,
    output logic                  err
);

    logic at_end;

    assign at_end = (cnt == WORD_OFF_W'(LINE_WORDS - 1));
    // An early r_last ends the burst too; the missing words are simply never written.
    assign done   = beat && (at_end || last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= done ? '0 : cnt + 1'b1;
            end
            if (beat && (last != at_end)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: looks up the tag array, refills a line over a burst
// read, writes the tag and replays the lookup. ICACHE_PERF_CNT_EN adds hit/miss counters.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_ctrl_if.master bus
);

    state_t                state;
    state_t                state_nx;
    logic [31:0]           addr_q;
    logic [WORD_OFF_W-1:0] cnt;
    logic                  accept;
    logic                  hit;
    logic                  beat;
    logic                  done;

    assign accept = (state == IDLE) && bus.req && bus.tag_work;
    assign hit    = bus.tag_hit && bus.tag_valid;
    assign beat   = (state == RD) && bus.r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= bus.addr;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        bus.ack      = 1'b0;
        bus.tag_wen  = 1'b0;
        bus.ar_valid = 1'b0;
        bus.r_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.ack  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = AR;
                end
            end
            AR: begin
                bus.ar_valid = 1'b1;
                if (bus.ar_ready) state_nx = RD;
            end
            RD: begin
                bus.r_ready = 1'b1;
                if (done) state_nx = TAGW;
            end
            TAGW: begin
                bus.tag_wen = 1'b1;
                state_nx    = REPLAY;
            end
            REPLAY: begin
                state_nx = LOOKUP;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    icache_refill_beat_cnt u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == AR),
        .beat (beat),
        .last (bus.r_last),
        .cnt  (cnt),
        .done (done),
        .err  (bus.err)
    );

    assign bus.stall = (state != IDLE) && !bus.ack;

    // The IDLE passthrough is forced to zero while reset is held so every output is quiet.
    assign bus.tag_addr   = (state != IDLE) ? addr_q : (rst ? bus.addr : '0);
    assign bus.tag_wdata  = tag_entry(addr_q[TAG_LSB +: TAG_W]);
    assign bus.data_wen   = beat;
    assign bus.data_waddr = {addr_q[INDEX_LSB +: INDEX_W], cnt};
    assign bus.data_wdata = beat ? bus.r_data : '0;
    assign bus.ar_addr    = {addr_q[31:OFFSET_W], OFFSET_W'(0)};
    assign bus.ar_len     = 8'(LINE_WORDS - 1);

`ifdef ICACHE_PERF_CNT_EN
    logic        replay_q;
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // A LOOKUP entered from REPLAY is the tail of a miss, not a fresh hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            replay_q <= (state == REPLAY);
            if (bus.ack && !replay_q && (hit_q != '1)) begin
                hit_q <= hit_q + 1'b1;
            end
            if ((state == LOOKUP) && !hit && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    assign bus.hit_cnt  = hit_q;
    assign bus.miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: tag array model, scripted memory read channel,
// hand-computed expectations for hits, misses, beat gaps, early r_last and mid-burst reset.
module tb_icache_refill_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    icache_refill_ctrl_if bus();

    icache_refill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tag array: synchronous read, result visible one cycle after tag_addr.
    logic [20:0] tag_mem [128];
    logic [31:0] tag_ra;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) tag_mem[i] <= '0;
            tag_ra <= '0;
        end else begin
            tag_ra <= bus.tag_addr;
            if (bus.tag_wen) tag_mem[bus.tag_addr[11:5]] <= bus.tag_wdata;
        end
    end

    assign bus.tag_valid = tag_mem[tag_ra[11:5]][20];
    assign bus.tag_hit   = (tag_mem[tag_ra[11:5]][19:0] == tag_ra[31:12]);

    int          r_ack_cyc, r_wen, r_twen, r_bad_addr, r_bad_data;
    int          r_stall_bad, r_ar_seen, r_ar_drop;
    logic        r_stall2;
    logic [20:0] r_twdata;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;

    // One fetch request, serviced by the scripted memory side. rst_at >= 0 pulls reset
    // while that beat index is on the bus and checks the outputs went quiet.
    task automatic run_req(input logic [31:0] a, input int ar_wait, input int gap,
                           input int last_at, input logic [31:0] dbase, input int rst_at);
        int n_arv, bi, gl;
        logic in_beats, pend, s_arv, s_arr, s_rv, s_rr;
        logic [9:0] base_wa;
        r_ack_cyc = 0; r_wen = 0; r_twen = 0; r_bad_addr = 0; r_bad_data = 0;
        r_stall_bad = 0; r_ar_seen = 0; r_ar_drop = 0; r_stall2 = 1'b0;
        r_twdata = '0; r_araddr = '0; r_arlen = '0;
        n_arv = 0; bi = 0; gl = 0; in_beats = 1'b0; pend = 1'b0;
        base_wa  = {a[11:5], 3'b000};
        bus.req  = 1'b1;
        bus.addr = a;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            s_arv = bus.ar_valid; s_arr = bus.ar_ready;
            s_rv  = bus.r_valid;  s_rr  = bus.r_ready;
            if (c == 2) r_stall2 = bus.stall;
            if (bus.stall !== (c > 1 && !bus.ack)) r_stall_bad++;
            if (pend && !bus.ar_valid) r_ar_drop++;
            pend = bus.ar_valid && !bus.ar_ready;
            if (bus.data_wen) begin
                if (bus.data_waddr !== base_wa + 10'(r_wen)) r_bad_addr++;
                if (bus.data_wdata !== dbase + 32'(r_wen)) r_bad_data++;
                r_wen++;
            end
            if (bus.tag_wen) begin
                r_twen++;
                r_twdata = bus.tag_wdata;
            end
            if (bus.ar_valid) begin
                r_ar_seen++;
                r_araddr = bus.ar_addr;
                r_arlen  = bus.ar_len;
            end
            if (bus.ack) begin
                r_ack_cyc = c;
                break;
            end
            @(posedge clk); #1;
            if (s_arv && s_arr) begin
                bus.ar_ready = 1'b0;
                in_beats     = 1'b1;
            end else if (s_arv) begin
                n_arv++;
                if (n_arv >= ar_wait) bus.ar_ready = 1'b1;
            end
            if (s_rv && s_rr) begin
                bi++;
                gl = gap;
            end
            if (in_beats && gl == 0 && bi <= last_at) begin
                bus.r_valid = 1'b1;
                bus.r_data  = dbase + 32'(bi);
                bus.r_last  = (bi == last_at);
            end else begin
                bus.r_valid = 1'b0;
                bus.r_last  = 1'b0;
                bus.r_data  = '0;
                if (gl > 0) gl--;
            end
            if (rst_at >= 0 && in_beats && bus.r_valid && bi == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_mid_stall",    bus.stall,    0);
                check("rst_mid_ack",      bus.ack,      0);
                check("rst_mid_r_ready",  bus.r_ready,  0);
                check("rst_mid_data_wen", bus.data_wen, 0);
                check("rst_mid_ar_valid", bus.ar_valid, 0);
                check("rst_mid_tag_wen",  bus.tag_wen,  0);
                check("rst_mid_err",      bus.err,      0);
                check("rst_mid_tag_addr", bus.tag_addr, 0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.req      = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_last   = 1'b0;
        bus.r_data   = '0;
        bus.ar_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b0;
        bus.req = 1'b0; bus.addr = '0; bus.tag_work = 1'b0;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall",    bus.stall,    0);
        check("reset_ack",      bus.ack,      0);
        check("reset_ar_valid", bus.ar_valid, 0);
        check("reset_r_ready",  bus.r_ready,  0);
        check("reset_tag_wen",  bus.tag_wen,  0);
        check("reset_data_wen", bus.data_wen, 0);
        check("reset_err",      bus.err,      0);
        check("reset_tag_addr", bus.tag_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Requests are ignored until the tag array reports init complete.
        bus.req = 1'b1; bus.addr = 32'h0000_1020;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.stall || bus.ack || bus.ar_valid) bad++;
            @(posedge clk); #1;
        end
        check("no_tag_work_ignored", bad, 0);
        bus.req = 1'b0;
        repeat (128) @(posedge clk);
        #1 bus.tag_work = 1'b1;

        run_req(32'h0000_1020, 0, 0, 7, 32'h200, -1);
        check("first_stall_next_cycle", r_stall2, 1);
        check("first_ack", r_ack_cyc != 0, 1);
        check("first_wen", r_wen, 8);

        // Cold miss, ar_ready after 3 cycles, back-to-back beats.
        run_req(32'hBFC0_0000, 3, 0, 7, 32'h100, -1);
        check("cold_ack",      r_ack_cyc != 0, 1);
        check("cold_wen",      r_wen,          8);
        check("cold_waddr",    r_bad_addr,     0);
        check("cold_wdata",    r_bad_data,     0);
        check("cold_tag_wen",  r_twen,         1);
        check("cold_tag_data", r_twdata,       21'h1BFC00);
        check("cold_ar_addr",  r_araddr,       32'hBFC0_0000);
        check("cold_ar_len",   r_arlen,        8'd7);
        check("cold_ar_wait",  r_ar_seen,      4);
        check("cold_ar_drop",  r_ar_drop,      0);
        check("cold_stall",    r_stall_bad,    0);
        check("cold_err",      bus.err,        0);

        run_req(32'hBFC0_0014, 0, 0, 7, 32'h0, -1);
        check("hit_latency", r_ack_cyc, 2);
        check("hit_no_ar",   r_ar_seen, 0);
        check("hit_no_wen",  r_wen,     0);
        check("hit_stall",   r_stall_bad, 0);

        // Beats arrive 1-on/2-off.
        run_req(32'h0000_2040, 1, 2, 7, 32'h300, -1);
        check("gap_ack",   r_ack_cyc != 0, 1);
        check("gap_wen",   r_wen,       8);
        check("gap_waddr", r_bad_addr,  0);
        check("gap_wdata", r_bad_data,  0);
        check("gap_err",   bus.err,     0);

        // r_last on beat 5: six words written, error latched, line still tagged.
        run_req(32'h0000_3060, 0, 0, 5, 32'h400, -1);
        check("early_ack",      r_ack_cyc != 0, 1);
        check("early_wen",      r_wen,      6);
        check("early_waddr",    r_bad_addr, 0);
        check("early_tag_wen",  r_twen,     1);
        check("early_tag_data", r_twdata,   21'h100003);
        check("early_err",      bus.err,    1);
        repeat (5) @(posedge clk);
        #1;
        run_req(32'h0000_3064, 0, 0, 7, 32'h0, -1);
        check("early_line_hit", r_ack_cyc, 2);
        check("err_sticky",     bus.err,   1);

        // Reset while beat 3 is on the bus.
        run_req(32'h0000_4080, 0, 0, 7, 32'h500, 3);
        check("rst_mid_beats_before", r_wen, 3);
        bus.r_valid = 1'b1; bus.r_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_stray_r_ready", bus.r_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_stall",    bus.stall,    0);
        check("rst_rel_r_ready",  bus.r_ready,  0);
        check("rst_rel_data_wen", bus.data_wen, 0);
        @(posedge clk); #1;
        bus.r_valid = 1'b0; bus.r_data = '0;

        run_req(32'h0000_5000, 0, 0, 7, 32'h600, -1);
        check("post_rst_miss_ack", r_ack_cyc != 0, 1);
        check("post_rst_miss_wen", r_wen, 8);
        run_req(32'h0000_5004, 0, 0, 7, 32'h0, -1);
        check("post_rst_hit_latency", r_ack_cyc, 2);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_miss_cnt", bus.miss_cnt, 1);
        check("perf_hit_cnt",  bus.hit_cnt,  1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
